// File: rtl/bus_generator_n_arbiter.sv
// Shared-bus generator/arbiter: per bus, round-robin pop of one device
// FIFO head, then unicast or broadcast push by destination ID.
module bus_generator_n_arbiter #(
  parameter int         bits      = 1,
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 32,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  output logic [bits-1:0][drvrs-1:0]              pop,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  // First pending index after ptr; the pointer itself is lowest priority.
  function automatic logic [IW-1:0] next_winner(
    input logic [drvrs-1:0] req,
    input logic [IW-1:0]    ptr
  );
    logic [IW-1:0] w;
    int            idx;
    w = ptr;
    for (int j = drvrs; j >= 1; j--) begin
      idx = (int'(ptr) + j) % drvrs;
      if (req[IW'(idx)]) w = IW'(idx);
    end
    return w;
  endfunction

  function automatic logic [drvrs-1:0] push_mask(
    input logic [7:0]    dest,
    input logic [IW-1:0] win
  );
    logic [drvrs-1:0] m;
    m = '0;
    if (dest == broadcast) begin
      m      = '1;
      m[win] = 1'b0;
    end else if (int'(dest) < drvrs) begin
      m[dest[IW-1:0]] = 1'b1;
    end
    return m;
  endfunction

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win;
    logic [IW-1:0]      grant;
    logic [pckg_sz-1:0] bus_data;
    logic [pckg_sz-1:0] data_q;
    logic [drvrs-1:0]   pop_q;
    logic [drvrs-1:0]   push_q;

    assign grant   = next_winner(pndng[b], ptr);
    assign pop[b]  = pop_q;
    assign push[b] = push_q;

    for (genvar i = 0; i < drvrs; i++) begin : g_lane
      assign D_push[b][i] = data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state    <= IDLE;
        ptr      <= IW'(drvrs - 1);
        win      <= '0;
        bus_data <= '0;
        data_q   <= '0;
        pop_q    <= '0;
        push_q   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            pop_q  <= '0;
            push_q <= '0;
            if (|pndng[b]) begin
              win      <= grant;
              ptr      <= grant;
              bus_data <= D_pop[b][grant];
              state    <= POP;
            end
          end
          POP: begin
            pop_q      <= '0;
            pop_q[win] <= 1'b1;
            push_q     <= '0;
            state      <= PUSH;
          end
          PUSH: begin
            pop_q  <= '0;
            push_q <= push_mask(bus_data[pckg_sz-1 -: 8], win);
            data_q <= bus_data;
            state  <= IDLE;
          end
          default: begin
            pop_q  <= '0;
            push_q <= '0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_generator_n_arbiter.sv
// Randomized and directed bench for bus_generator_n_arbiter with a
// transaction-level model of the arbitration and delivery rules.
module tb_bus_generator_n_arbiter;
  localparam int NB = 2;
  localparam int ND = 4;
  localparam int W  = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic [NB-1:0][ND-1:0]        pndng;
  logic [NB-1:0][ND-1:0]        pop;
  logic [NB-1:0][ND-1:0]        push;
  logic [NB-1:0][ND-1:0][W-1:0] D_pop;
  logic [NB-1:0][ND-1:0][W-1:0] D_push;

  bus_generator_n_arbiter #(
    .bits(NB), .drvrs(ND), .pckg_sz(W), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .pop(pop),
    .D_pop(D_pop), .push(push), .D_push(D_push)
  );

  always #5 clk = ~clk;

  logic rst_edge = 1'b1;
  always @(posedge clk) rst_edge <= reset;

  logic [W-1:0] fifo [NB][ND][$];
  logic [W-1:0] rx   [NB][ND][$];
  int           rxc  [NB][ND][$];
  logic [NB-1:0][ND-1:0] hide;
  int glog[$];
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int ptr[NB], win[NB], pop_at[NB], push_at[NB], free_at[NB];
  logic [W-1:0] mdata[NB], edp[NB];
  logic [W-1:0] a2o[4][4];
  int ord[3] = '{0, 1, 3};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int rr(input logic [ND-1:0] req, input int p);
    for (int k = 1; k <= ND; k++)
      if (req[(p + k) % ND]) return (p + k) % ND;
    return -1;
  endfunction

  function automatic logic [ND-1:0] tmask(input logic [W-1:0] p, input int w);
    int d;
    d = int'(p[W-1 -: 8]);
    tmask = '0;
    if (d == 255) begin
      tmask    = '1;
      tmask[w] = 1'b0;
    end else if (d < ND) begin
      tmask[d] = 1'b1;
    end
  endfunction

  function automatic logic [W-1:0] rpkt();
    int s;
    logic [7:0] d;
    s = $urandom_range(0, 5);
    d = (s < 4) ? 8'(s) : (s == 4) ? 8'hFF : 8'($urandom_range(4, 254));
    return {d, 24'($urandom)};
  endfunction

  function automatic logic [W-1:0] rxat(input int b, input int i, input int k);
    return (rx[b][i].size() > k) ? rx[b][i][k] : 32'hBAD0_BAD0;
  endfunction

  task automatic refresh();
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < ND; i++) begin
        pndng[b][i] = (fifo[b][i].size() > 0) && !hide[b][i];
        D_pop[b][i] = (fifo[b][i].size() > 0) ? fifo[b][i][0] : 32'hDEAD_BEEF;
      end
  endtask

  task automatic step();
    logic [ND-1:0] ep, eu;
    int w;
    @(negedge clk);
    cyc++;
    for (int b = 0; b < NB; b++) begin
      ep = '0;
      eu = '0;
      if (reset) begin
        ptr[b] = ND - 1;
        pop_at[b] = -1;
        push_at[b] = -1;
        free_at[b] = 0;
        edp[b] = '0;
      end else begin
        if (pop_at[b] == cyc) ep[win[b]] = 1'b1;
        if (push_at[b] == cyc) begin
          eu = tmask(mdata[b], win[b]);
          edp[b] = mdata[b];
        end
      end
      chk($sformatf("pop b%0d c%0d", b, cyc), 32'(pop[b]), 32'(ep));
      chk($sformatf("push b%0d c%0d", b, cyc), 32'(push[b]), 32'(eu));
      for (int i = 0; i < ND; i++)
        chk($sformatf("D_push b%0d l%0d c%0d", b, i, cyc), D_push[b][i], edp[b]);
      for (int i = 0; i < ND; i++)
        if (push[b][i]) begin
          rx[b][i].push_back(D_push[b][i]);
          rxc[b][i].push_back(cyc);
        end
      if (!reset && !rst_edge && cyc >= free_at[b] && pndng[b] != '0) begin
        w = rr(pndng[b], ptr[b]);
        win[b] = w;
        ptr[b] = w;
        mdata[b] = D_pop[b][w];
        pop_at[b] = cyc + 1;
        push_at[b] = cyc + 2;
        free_at[b] = cyc + 3;
        if (b == 0) glog.push_back(w);
      end
    end
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < ND; i++)
        if (pop[b][i] && fifo[b][i].size() > 0) void'(fifo[b][i].pop_front());
    refresh();
  endtask

  task automatic drain();
    int n;
    bit busy;
    n = 0;
    do begin
      step();
      n++;
      busy = 1'b0;
      for (int b = 0; b < NB; b++) begin
        if (cyc < free_at[b]) busy = 1'b1;
        for (int i = 0; i < ND; i++)
          if (fifo[b][i].size() > 0) busy = 1'b1;
      end
    end while (busy && n < 500);
    chk("drain finished", 32'(busy), 32'd0);
  endtask

  task automatic wait_pop(input int b, input string nm);
    int n;
    n = 0;
    do begin step(); n++; end while (pop[b] == '0 && n < 20);
    chk({nm, " pop seen"}, 32'(pop[b] != '0), 32'd1);
  endtask

  task automatic wait_push(input int b, input string nm);
    int n;
    n = 0;
    do begin step(); n++; end while (push[b] == '0 && n < 20);
    chk({nm, " push seen"}, 32'(push[b] != '0), 32'd1);
  endtask

  task automatic clr();
    glog.delete();
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < ND; i++) begin
        rx[b][i].delete();
        rxc[b][i].delete();
      end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic int rx_total();
    int s;
    s = 0;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < ND; i++) s += rx[b][i].size();
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hide = '0;
    for (int i = 0; i < ND; i++)
      fifo[0][i].push_back({8'((i + 1) % ND), 24'(i)});
    refresh();
    #1 reset = 1'b1;

    // reset held 50 ns with every source pending
    repeat (5) step();
    reset = 1'b0;
    clr();
    step();
    chk("first grant", 32'(glog.size() > 0 ? glog[0] : -1), 32'd0);
    step();
    chk("first pop", 32'(pop[0]), 32'b0001);
    drain();
    for (int i = 0; i < ND; i++)
      chk($sformatf("reset flush rx%0d", (i + 1) % ND),
          rxat(0, (i + 1) % ND, 0), {8'((i + 1) % ND), 24'(i)});

    // normal unicast
    clr();
    fifo[0][1].push_back(32'h02AB_CDEF);
    refresh();
    wait_pop(0, "normal");
    chk("normal pop", 32'(pop[0]), 32'b0010);
    step();
    chk("normal push", 32'(push[0]), 32'b0100);
    chk("normal data", D_push[0][2], 32'h02AB_CDEF);
    drain();

    // all_to_one
    pulse_reset();
    clr();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 3; j++) begin
        a2o[ord[j]][k] = {8'h02, 24'($urandom)};
        fifo[0][ord[j]].push_back(a2o[ord[j]][k]);
      end
    refresh();
    drain();
    chk("a2o grants", 32'(glog.size()), 32'd12);
    for (int j = 0; j < 12; j++)
      chk($sformatf("a2o grant %0d", j),
          32'(j < glog.size() ? glog[j] : -1), 32'(ord[j % 3]));
    chk("a2o rx2 count", 32'(rx[0][2].size()), 32'd12);
    chk("a2o other rx", 32'(rx_total() - rx[0][2].size()), 32'd0);
    for (int j = 0; j < 12; j++)
      chk($sformatf("a2o data %0d", j), rxat(0, 2, j), a2o[ord[j % 3]][j / 3]);

    // one_to_all
    clr();
    for (int t = 1; t < ND; t++)
      fifo[0][0].push_back({8'(t), 24'(24'hAB00 + t)});
    refresh();
    drain();
    for (int t = 1; t < ND; t++) begin
      chk($sformatf("o2a data %0d", t), rxat(0, t, 0), {8'(t), 24'(24'hAB00 + t)});
      chk($sformatf("o2a count %0d", t), 32'(rx[0][t].size()), 32'd1);
      if (rxc[0][t].size() > 0 && rxc[0][1].size() > 0)
        chk($sformatf("o2a spacing %0d", t),
            32'(rxc[0][t][0] - rxc[0][1][0]), 32'(3 * (t - 1)));
    end

    // broadcast from device 3
    clr();
    fifo[0][3].push_back(32'hFF00_1234);
    refresh();
    wait_push(0, "bcast");
    chk("bcast push", 32'(push[0]), 32'b0111);
    for (int i = 0; i < ND; i++)
      chk($sformatf("bcast data l%0d", i), D_push[0][i], 32'hFF00_1234);
    drain();

    // invalid destination is dropped after the pop
    clr();
    fifo[0][2].push_back(32'h0700_0055);
    refresh();
    wait_pop(0, "invalid");
    chk("invalid pop", 32'(pop[0]), 32'b0100);
    step();
    chk("invalid push", 32'(push[0]), 32'd0);
    drain();
    chk("invalid rx total", 32'(rx_total()), 32'd0);
    fifo[0][2].push_back(32'h0100_0066);
    refresh();
    drain();
    chk("after invalid", rxat(0, 1, 0), 32'h0100_0066);

    // pndng dropping after the grant does not cancel the transfer
    clr();
    fifo[0][2].push_back(32'h03C0_FFEE);
    refresh();
    step();
    hide[0][2] = 1'b1;
    refresh();
    drain();
    hide = '0;
    refresh();
    chk("late pndng drop", rxat(0, 3, 0), 32'h03C0_FFEE);

    // both buses at once
    clr();
    fifo[0][1].push_back(32'h0011_2233);
    fifo[1][1].push_back(32'h0344_5566);
    refresh();
    drain();
    chk("bus0 rx0", rxat(0, 0, 0), 32'h0011_2233);
    chk("bus1 rx3", rxat(1, 3, 0), 32'h0344_5566);
    chk("bus cross", 32'(rx[0][3].size() + rx[1][0].size()), 32'd0);

    // asynchronous reset while push is high
    clr();
    fifo[0][1].push_back(32'h0000_4242);
    refresh();
    wait_push(0, "async");
    chk("async push before", 32'(push[0]), 32'b0001);
    #2 reset = 1'b1;
    #1;
    chk("async push drop", 32'(push[0]), 32'd0);
    chk("async pop drop", 32'(pop[0]), 32'd0);
    chk("async data drop", D_push[0][0], 32'd0);
    step();
    reset = 1'b0;
    drain();

    // randomized traffic on both buses
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 2) == 0) begin
          int i;
          i = $urandom_range(0, ND - 1);
          if (fifo[b][i].size() < 4) fifo[b][i].push_back(rpkt());
        end
      refresh();
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
